shot_scheduler: RTL and testbench
=================================

Name: shot_scheduler

Overview:
- Owns a pool of projectile slots for the VGA shooter game and shares it between two shot requesters: player (mouse click path) and enemy AI.
- Arbitrates and allocates slots, and sequences a once-per-frame position update of every live projectile.
- Frees slots on leaving the 800x600 screen or on a hit report.
- Exposes a registered slot read port to the sprite renderer in the VGA pipeline.

Parameters:
- NUM_SLOTS, 4, number of projectile slots (2..8).
- COOLDOWN_FRAMES, 8, frames a requester is blocked after a granted shot.
- X_MAX, 798, largest live x coordinate.
- Y_MAX, 598, largest live y coordinate.

Ports:
- clk  in  1  pixel clock, posedge.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- req  in  2  shot request; [0] player, [1] enemy; level, held until ack or rej.
- req_x  in  2x12  launch x per requester (unsigned).
- req_y  in  2x12  launch y per requester (unsigned).
- req_vx  in  2x8  x velocity per requester, signed pixels/frame.
- req_vy  in  2x8  y velocity per requester, signed pixels/frame.
- ack  out  2  one-cycle pulse: shot accepted.
- rej  out  2  one-cycle pulse: shot refused (pool full or cooldown).
- hit_valid  in  1  collision report strobe.
- hit_idx  in  3  slot index hit.
- rd_idx  in  3  renderer slot select.
- rd_valid  out  1  selected slot is live (registered).
- rd_x  out  12  selected slot position x (registered).
- rd_y  out  12  selected slot position y (registered).
- rd_owner  out  1  0 player, 1 enemy (registered).
- busy  out  1  high while in UPDATE.

Behaviour:
- Reset: all slots invalid, positions 0, cooldowns 0, state IDLE, round-robin pointer to player.
  - All outputs 0 on the cycle after rst is sampled high.
  - Reset mid-UPDATE aborts the sweep.
- Slot contents: valid, x[11:0], y[11:0], vx[7:0], vy[7:0], owner.
- FSM states:
  - IDLE: service requests. frame_tick -> UPDATE with idx=0.
  - UPDATE: process slot idx, one slot per cycle. idx==NUM_SLOTS-1 -> DONE.
  - DONE: decrement non-zero cooldowns by 1. -> IDLE.
- Requests are serviced only in IDLE.
  - A requester is eligible when its req=1 and its ack/rej are 0 this cycle.
  - During UPDATE/DONE, requests wait; no ack/rej is issued.
  - One requester is decided per cycle.
- Arbitration: 2-way round robin. The pointer moves past the granted/refused requester after each decision.
- Decision:
  - cooldown!=0 or no free slot -> rej pulse next cycle; no slot change.
  - Otherwise:
    - Allocate the lowest-index free slot with the request's fields.
    - Set that requester's cooldown to COOLDOWN_FRAMES.
    - ack pulse next cycle; the slot is readable on the following cycle.
- frame_tick arriving in the same IDLE cycle as a decision: the decision completes, then the FSM goes to UPDATE. A frame_tick outside IDLE is ignored.
- Position update arithmetic:
  - nx = {1'b0,x} + sext13(vx) in 13-bit signed; ny likewise.
  - Slot stays live iff 1<=nx<=X_MAX and 0<=ny<=Y_MAX; it stores nx[11:0], ny[11:0].
  - Otherwise valid is cleared.
  - Invalid slots are skipped but still take one cycle.
  - UPDATE length is exactly NUM_SLOTS cycles.
- Hits:
  - hit_valid clears slot hit_idx the next cycle in any state.
  - A hit on the slot being updated in the same cycle wins: the slot ends invalid.
  - hit_idx >= NUM_SLOTS is ignored.
  - A hit on an invalid slot has no effect.
- Read port: rd_* reflect the slot state one cycle after rd_idx is presented. rd_idx >= NUM_SLOTS -> rd_valid=0.
- A slot freed by a hit and a new allocation in the same cycle: the allocation sees the slot as still occupied (uses the pre-cycle state).

Optional Feature:
- SHOT_SCHED_STATS_EN defined:
  - Adds outputs shots_fired[15:0] (counts acks) and shots_refused[15:0] (counts rejs).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- shot_sched_pkg holds:
  - screen constants (SCREEN_W=800, SCREEN_H=600);
  - slot struct typedef;
  - FSM state enum (IDLE, UPDATE, DONE);
  - owner encoding constants.
- Sub-module shot_rr_arbiter: 2-way round-robin picker with pointer register. Inputs eligible[1:0] and advance; output grant one-hot.

Test Plan:
- Player req, x=400 y=590 vx=0 vy=-10; then a frame_tick -> ack[0] one cycle after decision, slot0 valid; after the sweep rd_idx=0 gives rd_y=580.
- Player and enemy req in the same IDLE cycle after reset -> player acked first, enemy acked the following cycle; slots 0 and 1 allocated, owners 0 and 1.
- Player fires and is acked, re-requests at once -> rej[0]; after 8 frame_ticks a request -> ack[0].
- Fill 4 slots (cooldowns forced clear across frames), then a 5th request -> rej; hit_idx=2 -> the next request lands in slot 2.
- Slot at x=5 with vx=-5 -> after the sweep rd_valid=0; slot at y=595 with vy=+3 -> stays live at y=598.
- rst asserted on UPDATE cycle 2 -> next cycle all rd_valid=0, busy=0, ack=rej=0; with SHOT_SCHED_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/shot_sched_pkg.sv
// shot_sched_pkg: shared types and constants for the projectile pool.
//   - screen geometry, slot record, FSM state encoding, owner encoding
//   - step_pos(): one-frame position step in 13-bit signed arithmetic
package shot_sched_pkg;

  localparam int SCREEN_W  = 800;
  localparam int SCREEN_H  = 600;

  // Storage is always sized for the largest legal pool; only the first
  // NUM_SLOTS entries are ever allocated.
  localparam int MAX_SLOTS = 8;
  localparam int IDX_W     = 3;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_ENEMY  = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic        owner;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Zero-extended position plus sign-extended velocity. The extra bit
  // lets a step below 0 or beyond 4095 show up as out of range.
  function automatic logic signed [12:0] step_pos(input logic [11:0] pos,
                                                  input logic [7:0]  vel);
    return $signed({1'b0, pos}) + $signed({{5{vel[7]}}, vel});
  endfunction

endpackage

// File: rtl/shot_rr_arbiter.sv
// shot_rr_arbiter: 2-way round-robin picker.
//   clk, rst   : clock, synchronous active-high reset (pointer -> requester 0)
//   eligible   : [0] player, [1] enemy
//   advance    : a decision was taken this cycle; pointer moves past the winner
//   grant      : one-hot winner (combinational), 0 when nobody is eligible
module shot_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr names the requester that currently has priority.
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (eligible[0])      grant = 2'b01;
      else if (eligible[1]) grant = 2'b10;
    end else begin
      if (eligible[1])      grant = 2'b10;
      else if (eligible[0]) grant = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      // Winner 0 hands priority to 1 and vice versa.
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/shot_scheduler.sv
// shot_scheduler: projectile slot pool shared by player and enemy shooters.
//   clk, rst       : pixel clock; synchronous active-high reset
//   frame_tick     : start-of-vblank pulse, launches the per-frame sweep
//   req/ack/rej    : per requester ([0] player, [1] enemy) shot handshake
//   req_x/y/vx/vy  : launch position and signed per-frame velocity
//   hit_valid/idx  : collision report, frees the named slot
//   rd_idx -> rd_* : registered slot read port for the sprite renderer
//   busy           : high while the position sweep runs
//   dbg_state      : current FSM state
//   shots_fired/shots_refused : saturating ack/rej counters, present only
//                    when SHOT_SCHED_STATS_EN is defined
//
// Handshake: a requester raises req and holds it until a one-cycle ack or
// rej pulse; it is not considered again in the cycle that pulse is high.
// Requests are decided one per cycle, only while the FSM is idle.
module shot_scheduler
  import shot_sched_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int X_MAX           = SCREEN_W - 2,
  parameter int Y_MAX           = SCREEN_H - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [1:0]       req,
  input  logic [1:0][11:0] req_x,
  input  logic [1:0][11:0] req_y,
  input  logic [1:0][7:0]  req_vx,
  input  logic [1:0][7:0]  req_vy,
  output logic [1:0]       ack,
  output logic [1:0]       rej,
  input  logic             hit_valid,
  input  logic [2:0]       hit_idx,
  input  logic [2:0]       rd_idx,
  output logic             rd_valid,
  output logic [11:0]      rd_x,
  output logic [11:0]      rd_y,
  output logic             rd_owner,
`ifdef SHOT_SCHED_STATS_EN
  output logic [15:0]      shots_fired,
  output logic [15:0]      shots_refused,
`endif
  output logic             busy,
  output state_t           dbg_state
);

  localparam int                 CD_W        = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0]    CD_INIT     = CD_W'(COOLDOWN_FRAMES);
  localparam logic [3:0]         NUM_SLOTS_W = 4'(NUM_SLOTS);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_SLOTS - 1);
  localparam logic signed [12:0] X_MAX_S     = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S     = 13'(Y_MAX);

  state_t           state;
  logic [IDX_W-1:0] idx;
  slot_t            slots [MAX_SLOTS];
  logic [CD_W-1:0]  cooldown [2];

  // ---------------- arbitration ----------------
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       decide;
  logic       gsel;
  logic       refuse;

  assign eligible = req & ~ack & ~rej & {2{state == ST_IDLE}};
  assign decide   = (grant != 2'b00);
  assign gsel     = grant[1];

  shot_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .advance  (decide),
    .grant    (grant)
  );

  // Lowest-index free slot, judged on the registered (pre-cycle) state so a
  // slot freed by a hit this cycle is not yet reusable.
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign refuse = (cooldown[gsel] != '0) || !free_found;

  // ---------------- sweep arithmetic ----------------
  slot_t              cur;
  logic signed [12:0] nx;
  logic signed [12:0] ny;
  logic               live;

  assign cur  = slots[idx];
  assign nx   = step_pos(cur.x, cur.vx);
  assign ny   = step_pos(cur.y, cur.vy);
  // x == 0 counts as off-screen on the left; y == 0 is still on-screen.
  assign live = (nx >= 13'sd1) && (nx <= X_MAX_S) &&
                (ny >= 13'sd0) && (ny <= Y_MAX_S);

  // A hit only acts on a live in-range slot, so it can never cancel an
  // allocation landing in the same (previously free) slot.
  logic hit_ok;
  assign hit_ok = hit_valid && ({1'b0, hit_idx} < NUM_SLOTS_W) &&
                  slots[hit_idx].valid;

  // ---------------- FSM and slot state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      ack   <= 2'b00;
      rej   <= 2'b00;
      for (int i = 0; i < MAX_SLOTS; i++) slots[i] <= '0;
      cooldown[0] <= '0;
      cooldown[1] <= '0;
    end else begin
      ack <= 2'b00;
      rej <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (decide) begin
            if (refuse) begin
              rej[gsel] <= 1'b1;
            end else begin
              ack[gsel]      <= 1'b1;
              cooldown[gsel] <= CD_INIT;
              slots[free_idx] <= '{valid: 1'b1,
                                   x:     req_x[gsel],
                                   y:     req_y[gsel],
                                   vx:    req_vx[gsel],
                                   vy:    req_vy[gsel],
                                   owner: gsel ? OWNER_ENEMY : OWNER_PLAYER};
            end
          end
          // The decision above still completes when the tick lands here.
          if (frame_tick) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          // Dead slots are skipped but still cost their cycle, keeping the
          // sweep length fixed at NUM_SLOTS.
          if (cur.valid) begin
            if (live) begin
              slots[idx].x <= nx[11:0];
              slots[idx].y <= ny[11:0];
            end else begin
              slots[idx].valid <= 1'b0;
            end
          end
          if (idx == LAST_IDX) state <= ST_DONE;
          else                 idx   <= idx + IDX_W'(1);
        end
        ST_DONE: begin
          for (int r = 0; r < 2; r++) begin
            if (cooldown[r] != '0) cooldown[r] <= cooldown[r] - CD_W'(1);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Last assignment wins: a hit overrides a same-cycle sweep write.
      if (hit_ok) slots[hit_idx].valid <= 1'b0;
    end
  end

  assign busy      = (state == ST_UPDATE);
  assign dbg_state = state;

  // ---------------- renderer read port ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      rd_owner <= 1'b0;
    end else if ({1'b0, rd_idx} < NUM_SLOTS_W) begin
      rd_valid <= slots[rd_idx].valid;
      rd_x     <= slots[rd_idx].x;
      rd_y     <= slots[rd_idx].y;
      rd_owner <= slots[rd_idx].owner;
    end else begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      rd_owner <= 1'b0;
    end
  end

`ifdef SHOT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      shots_fired   <= '0;
      shots_refused <= '0;
    end else if (decide) begin
      if (refuse) begin
        if (shots_refused != 16'hFFFF) shots_refused <= shots_refused + 16'd1;
      end else begin
        if (shots_fired != 16'hFFFF) shots_fired <= shots_fired + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_shot_scheduler.sv
// tb_shot_scheduler: directed self-checking bench for shot_scheduler
// (default parameters: 4 slots, 8-frame cooldown, 798x598 live area).
module tb_shot_scheduler;
  import shot_sched_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             frame_tick = 1'b0;
  logic [1:0]       req        = 2'b00;
  logic [1:0][11:0] req_x      = '0;
  logic [1:0][11:0] req_y      = '0;
  logic [1:0][7:0]  req_vx     = '0;
  logic [1:0][7:0]  req_vy     = '0;
  logic [1:0]       ack;
  logic [1:0]       rej;
  logic             hit_valid  = 1'b0;
  logic [2:0]       hit_idx    = 3'd0;
  logic [2:0]       rd_idx     = 3'd0;
  logic             rd_valid;
  logic [11:0]      rd_x;
  logic [11:0]      rd_y;
  logic             rd_owner;
  logic             busy;
  state_t           dbg_state;
`ifdef SHOT_SCHED_STATS_EN
  logic [15:0]      shots_fired;
  logic [15:0]      shots_refused;
`endif

  always #5 clk = ~clk;

  shot_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .req           (req),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_vx        (req_vx),
    .req_vy        (req_vy),
    .ack           (ack),
    .rej           (rej),
    .hit_valid     (hit_valid),
    .hit_idx       (hit_idx),
    .rd_idx        (rd_idx),
    .rd_valid      (rd_valid),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_owner      (rd_owner),
`ifdef SHOT_SCHED_STATS_EN
    .shots_fired   (shots_fired),
    .shots_refused (shots_refused),
`endif
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] exp_q[$];   // {valid, x[11:0], y[11:0], owner}

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    req        = 2'b00;
    frame_tick = 1'b0;
    hit_valid  = 1'b0;
    rd_idx     = 3'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise one request and hold it until ack or rej (bounded wait).
  task automatic fire(input int who, input int x, input int y,
                      input int vx, input int vy,
                      output logic got_ack, output logic got_rej,
                      output int lat);
    req_x[who]  = 12'(x);
    req_y[who]  = 12'(y);
    req_vx[who] = 8'(vx);
    req_vy[who] = 8'(vy);
    req[who]    = 1'b1;
    lat     = 0;
    got_ack = 1'b0;
    got_rej = 1'b0;
    while (!got_ack && !got_rej && lat < 40) begin
      tick();
      lat++;
      got_ack = ack[who];
      got_rej = rej[who];
    end
    req[who] = 1'b0;
  endtask

  task automatic fire_expect(input string tag, input int who, input int x,
                             input int y, input int vx, input int vy,
                             input logic want_ack);
    logic a, r;
    int   lat;
    fire(who, x, y, vx, vy, a, r, lat);
    check_eq({tag, " ack"}, 32'(a), 32'(want_ack));
    check_eq({tag, " rej"}, 32'(r), 32'(!want_ack));
  endtask

  // One frame: tick pulse, count busy cycles, then let DONE retire.
  task automatic frame_pulse(output int busy_cycles);
    frame_tick = 1'b1;
    tick();
    frame_tick  = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      busy_cycles++;
      tick();
    end
    tick();
  endtask

  task automatic frames(input int n);
    int bc;
    for (int i = 0; i < n; i++) frame_pulse(bc);
  endtask

  task automatic expect_slot(input int idx, input logic v, input int x,
                             input int y, input logic own);
    logic [25:0] e;
    exp_q.push_back({v, 12'(x), 12'(y), own});
    rd_idx = 3'(idx);
    tick();
    e = exp_q.pop_front();
    check_eq($sformatf("slot%0d valid", idx), 32'(rd_valid), 32'(e[25]));
    if (e[25]) begin
      check_eq($sformatf("slot%0d x", idx),     32'(rd_x),     32'(e[24:13]));
      check_eq($sformatf("slot%0d y", idx),     32'(rd_y),     32'(e[12:1]));
      check_eq($sformatf("slot%0d owner", idx), 32'(rd_owner), 32'(e[0]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a, r;
    int   lat, bc;

    // Reset state
    reset_dut();
    check_eq("reset state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("reset ack",   32'(ack),  32'd0);
    check_eq("reset rej",   32'(rej),  32'd0);
    check_eq("reset busy",  32'(busy), 32'd0);
    expect_slot(0, 1'b0, 0, 0, 1'b0);

    // Simultaneous requests: player first, enemy the next cycle
    req_x[0] = 12'd100; req_y[0] = 12'd100;
    req_x[1] = 12'd200; req_y[1] = 12'd50;
    req_vx   = '0;      req_vy   = '0;
    req      = 2'b11;
    tick();
    check_eq("both first ack", 32'(ack), 32'd1);
    req[0] = 1'b0;
    tick();
    check_eq("both second ack", 32'(ack), 32'd2);
    req[1] = 1'b0;
    expect_slot(0, 1'b1, 100, 100, 1'b0);
    expect_slot(1, 1'b1, 200, 50, 1'b1);

    // Basic fire, sweep, cooldown
    reset_dut();
    fire(0, 400, 590, 0, -10, a, r, lat);
    check_eq("fire ack", 32'(a), 32'd1);
    check_eq("fire ack latency", 32'(lat), 32'd1);
    expect_slot(0, 1'b1, 400, 590, 1'b0);
    frame_pulse(bc);
    check_eq("update length", 32'(bc), 32'd4);
    expect_slot(0, 1'b1, 400, 580, 1'b0);
    fire_expect("cooldown refuse", 0, 400, 590, 0, -10, 1'b0);
    frames(8);
    expect_slot(0, 1'b1, 400, 500, 1'b0);
    fire_expect("cooldown expired", 0, 400, 590, 0, -10, 1'b1);
    expect_slot(1, 1'b1, 400, 590, 1'b0);

    // Pool full, hits, reuse of a freed slot
    reset_dut();
    fire_expect("fill0", 0, 100, 100, 0, 0, 1'b1);
    fire_expect("fill1", 1, 200, 100, 0, 0, 1'b1);
    frames(8);
    fire_expect("fill2", 0, 300, 100, 0, 0, 1'b1);
    fire_expect("fill3", 1, 400, 100, 0, 0, 1'b1);
    frames(8);
    fire_expect("pool full", 0, 600, 100, 0, 0, 1'b0);
    hit_idx = 3'd5; hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    expect_slot(3, 1'b1, 400, 100, 1'b1);
    hit_idx = 3'd2; hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    expect_slot(2, 1'b0, 0, 0, 1'b0);
    fire_expect("refill", 1, 500, 200, 0, 0, 1'b1);
    expect_slot(2, 1'b1, 500, 200, 1'b1);
    expect_slot(5, 1'b0, 0, 0, 1'b0);
`ifdef SHOT_SCHED_STATS_EN
    check_eq("shots_fired",   32'(shots_fired),   32'd5);
    check_eq("shots_refused", 32'(shots_refused), 32'd1);
`endif

    // Screen-edge boundaries
    reset_dut();
    fire_expect("edge x", 0, 5, 300, -5, 0, 1'b1);
    fire_expect("edge y", 1, 300, 595, 0, 3, 1'b1);
    frames(1);
    expect_slot(0, 1'b0, 0, 0, 1'b0);
    expect_slot(1, 1'b1, 300, 598, 1'b1);
    frames(1);
    expect_slot(1, 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a sweep
    reset_dut();
    fire_expect("pre-abort", 0, 400, 300, 0, 0, 1'b1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_eq("busy in sweep", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort busy",     32'(busy),      32'd0);
    check_eq("abort ack",      32'(ack),       32'd0);
    check_eq("abort rej",      32'(rej),       32'd0);
    check_eq("abort state",    32'(dbg_state), 32'(ST_IDLE));
    check_eq("abort rd_valid", 32'(rd_valid),  32'd0);
`ifdef SHOT_SCHED_STATS_EN
    check_eq("abort shots_fired",   32'(shots_fired),   32'd0);
    check_eq("abort shots_refused", 32'(shots_refused), 32'd0);
`endif
    expect_slot(0, 1'b0, 0, 0, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
